// File: rtl/elevator_ctrl_n.sv
// elevator_ctrl_n: N-floor elevator controller with SCAN (direction-preserving) scheduling.
// Merges the tick prescaler, request latching, destination selection and car FSM into one block.
//
// Ports:
//   clk        system clock, all logic on rising edge
//   resetn     synchronous reset, active-HIGH (1 = reset), overrides enable
//   enable     global run enable; 0 freezes every register
//   open/shut  door open / close requests (level)
//   btncar     in-car floor buttons, bit i = floor i+1
//   btnout     hall call buttons, bit i = floor i+1
//   location   current car floor (1..FLOORS)
//   dest       selected target floor, 0 = none
//   state      0 idle, 1 moving up, 2 moving down, 3 door open
//   dir        travel preference, 1 = up
//   btnidccar  latched car requests
//   btnidcout  latched hall requests
//   doorcnt    door-open tick count
//   movecnt    inter-floor tick count
module elevator_ctrl_n #(
  parameter int unsigned FLOORS     = 5,
  parameter int unsigned FLOOR_W    = 4,
  parameter int unsigned TICK_DIV   = 100000000,
  parameter int unsigned DOOR_TICKS = 3,
  parameter int unsigned MOVE_TICKS = 3,
  parameter int unsigned CNT_W      = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               enable,
  input  logic               open,
  input  logic               shut,
  input  logic [FLOORS-1:0]  btncar,
  input  logic [FLOORS-1:0]  btnout,
  output logic [FLOOR_W-1:0] location,
  output logic [FLOOR_W-1:0] dest,
  output logic [1:0]         state,
  output logic               dir,
  output logic [FLOORS-1:0]  btnidccar,
  output logic [FLOORS-1:0]  btnidcout,
  output logic [CNT_W-1:0]   doorcnt,
  output logic [CNT_W-1:0]   movecnt
);

  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]   DOOR_LAST = CNT_W'(DOOR_TICKS - 1);
  localparam logic [CNT_W-1:0]   MOVE_LAST = CNT_W'(MOVE_TICKS - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StUp   = 2'd1;
  localparam logic [1:0] StDn   = 2'd2;
  localparam logic [1:0] StDoor = 2'd3;

  // One-hot mask of a floor number; floor 0 ("none") yields an empty mask.
  function automatic logic [FLOORS-1:0] floor_mask(input logic [FLOOR_W-1:0] f);
    logic [FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < int'(FLOORS); i++) begin
      if (f == FLOOR_W'(i + 1)) m[i] = 1'b1;
    end
    return m;
  endfunction

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [FLOOR_W-1:0] loc_q, loc_d;
  logic [FLOOR_W-1:0] dest_q, dest_d;
  logic [1:0]         state_q, state_d;
  logic               dir_q, dir_d;
  logic [FLOORS-1:0]  car_q, car_d;
  logic [FLOORS-1:0]  out_q, out_d;
  logic [CNT_W-1:0]   doorcnt_q, doorcnt_d;
  logic [CNT_W-1:0]   movecnt_q, movecnt_d;

  // ---------------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------------
  logic tick;

  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? '0 : presc_q + PRESC_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Destination selection (SCAN): nearest pending floor ahead in the current
  // direction, otherwise the nearest pending floor behind.
  // ---------------------------------------------------------------------------
  logic [FLOORS-1:0]  pending;
  logic [FLOOR_W-1:0] up_near;
  logic [FLOOR_W-1:0] dn_near;

  always_comb begin
    pending = car_q | out_q;
    up_near = '0;
    dn_near = '0;
    // Scan downwards so the last hit is the lowest floor above location.
    for (int i = int'(FLOORS); i >= 1; i--) begin
      if (pending[i-1] && (FLOOR_W'(i) > loc_q)) up_near = FLOOR_W'(i);
    end
    // Scan upwards so the last hit is the highest floor below location.
    for (int i = 1; i <= int'(FLOORS); i++) begin
      if (pending[i-1] && (FLOOR_W'(i) < loc_q)) dn_near = FLOOR_W'(i);
    end
    if (dir_q) begin
      dest_d = (up_near != '0) ? up_near : dn_near;
    end else begin
      dest_d = (dn_near != '0) ? dn_near : up_near;
    end
  end

  // ---------------------------------------------------------------------------
  // Car FSM
  // ---------------------------------------------------------------------------
  logic [FLOOR_W-1:0] loc_step;   // floor reached at the end of the current hop
  logic [FLOOR_W-1:0] clr_floor;  // floor whose requests clear this edge, 0 = none
  logic               pend_here;
  logic               pend_step;

  always_comb begin
    loc_step  = (state_q == StUp) ? loc_q + FLOOR_W'(1) : loc_q - FLOOR_W'(1);
    pend_here = |(pending & floor_mask(loc_q));
    pend_step = |(pending & floor_mask(loc_step));

    state_d   = state_q;
    dir_d     = dir_q;
    loc_d     = loc_q;
    doorcnt_d = doorcnt_q;
    movecnt_d = movecnt_q;
    clr_floor = '0;

    case (state_q)
      StIdle: begin
        if (pend_here || open) begin
          state_d   = StDoor;
          doorcnt_d = '0;
          clr_floor = loc_q;
        end else if (dest_q > loc_q) begin
          state_d = StUp;
          dir_d   = 1'b1;
        end else if ((dest_q != '0) && (dest_q < loc_q)) begin
          state_d = StDn;
          dir_d   = 1'b0;
        end
      end

      StUp, StDn: begin
        if (tick) begin
          if (movecnt_q == MOVE_LAST) begin
            loc_d     = loc_step;
            movecnt_d = '0;
            if (pend_step) begin
              state_d   = StDoor;
              doorcnt_d = '0;
              clr_floor = loc_step;
            end
          end else begin
            movecnt_d = movecnt_q + CNT_W'(1);
          end
        end
      end

      StDoor: begin
        if (open) begin
          doorcnt_d = '0;
        end else if (shut) begin
          state_d   = StIdle;
          doorcnt_d = '0;
        end else if (tick) begin
          if (doorcnt_q == DOOR_LAST) begin
            state_d   = StIdle;
            doorcnt_d = '0;
          end else begin
            doorcnt_d = doorcnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request latching
  // ---------------------------------------------------------------------------
  logic [FLOORS-1:0] btn_mask;
  logic [FLOORS-1:0] clr_mask;

  always_comb begin
    // Presses for the floor the door is open at are already being served.
    btn_mask = (state_q == StDoor) ? floor_mask(loc_q) : '0;
    clr_mask = floor_mask(clr_floor);
    car_d    = (car_q | (btncar & ~btn_mask)) & ~clr_mask;
    out_d    = (out_q | (btnout & ~btn_mask)) & ~clr_mask;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (resetn) begin
      presc_q   <= '0;
      loc_q     <= FLOOR_W'(1);
      dest_q    <= '0;
      state_q   <= StIdle;
      dir_q     <= 1'b1;
      car_q     <= '0;
      out_q     <= '0;
      doorcnt_q <= '0;
      movecnt_q <= '0;
    end else if (enable) begin
      presc_q   <= presc_d;
      loc_q     <= loc_d;
      dest_q    <= dest_d;
      state_q   <= state_d;
      dir_q     <= dir_d;
      car_q     <= car_d;
      out_q     <= out_d;
      doorcnt_q <= doorcnt_d;
      movecnt_q <= movecnt_d;
    end
  end

  assign location  = loc_q;
  assign dest      = dest_q;
  assign state     = state_q;
  assign dir       = dir_q;
  assign btnidccar = car_q;
  assign btnidcout = out_q;
  assign doorcnt   = doorcnt_q;
  assign movecnt   = movecnt_q;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// tb_elevator_ctrl_n: directed self-checking bench for elevator_ctrl_n
// (FLOORS=5, TICK_DIV=4, DOOR_TICKS=3, MOVE_TICKS=3). Inputs change and outputs are
// sampled on the falling edge; edge numbers in comments count rising edges after reset.
module tb_elevator_ctrl_n;

  logic       clk = 1'b0;
  logic       resetn;
  logic       enable;
  logic       open;
  logic       shut;
  logic [4:0] btncar;
  logic [4:0] btnout;
  logic [3:0] location;
  logic [3:0] dest;
  logic [1:0] state;
  logic       dir;
  logic [4:0] btnidccar;
  logic [4:0] btnidcout;
  logic [1:0] doorcnt;
  logic [1:0] movecnt;

  int checks = 0;
  int errors = 0;

  elevator_ctrl_n #(
    .FLOORS    (5),
    .FLOOR_W   (4),
    .TICK_DIV  (4),
    .DOOR_TICKS(3),
    .MOVE_TICKS(3),
    .CNT_W     (2)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .enable   (enable),
    .open     (open),
    .shut     (shut),
    .btncar   (btncar),
    .btnout   (btnout),
    .location (location),
    .dest     (dest),
    .state    (state),
    .dir      (dir),
    .btnidccar(btnidccar),
    .btnidcout(btnidcout),
    .doorcnt  (doorcnt),
    .movecnt  (movecnt)
  );

  always #5 clk = ~clk;

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_loc"},  32'(location),  32'd1);
    chk({tag, "_st"},   32'(state),     32'd0);
    chk({tag, "_dest"}, 32'(dest),      32'd0);
    chk({tag, "_dir"},  32'(dir),       32'd1);
    chk({tag, "_car"},  32'(btnidccar), 32'd0);
    chk({tag, "_out"},  32'(btnidcout), 32'd0);
    chk({tag, "_dc"},   32'(doorcnt),   32'd0);
    chk({tag, "_mc"},   32'(movecnt),   32'd0);
  endtask

  initial begin
    resetn = 1'b1;
    enable = 1'b1;
    open   = 1'b0;
    shut   = 1'b0;
    btncar = '0;
    btnout = '0;

    // Reset held for two cycles
    adv(2);
    chk_reset("rst");

    // Single trip 1 -> 3
    resetn = 1'b0;
    btncar = 5'b00100;
    adv(1);                                     // e1
    btncar = '0;
    chk("trip_car_latch", 32'(btnidccar), 32'b00100);
    chk("trip_dest_e1",   32'(dest),      32'd0);
    adv(1);                                     // e2
    chk("trip_dest",      32'(dest),      32'd3);
    chk("trip_idle_e2",   32'(state),     32'd0);
    adv(1);                                     // e3
    chk("trip_up",        32'(state),     32'd1);
    chk("trip_dir",       32'(dir),       32'd1);
    adv(8);                                     // e11
    chk("trip_loc_e11",   32'(location),  32'd1);
    chk("trip_mc_e11",    32'(movecnt),   32'd2);
    adv(1);                                     // e12
    chk("trip_loc2",      32'(location),  32'd2);
    chk("trip_mc_wrap",   32'(movecnt),   32'd0);
    chk("trip_st_e12",    32'(state),     32'd1);
    adv(11);                                    // e23
    chk("trip_loc_e23",   32'(location),  32'd2);
    adv(1);                                     // e24
    chk("trip_loc3",      32'(location),  32'd3);
    chk("trip_door",      32'(state),     32'd3);
    chk("trip_car_clr",   32'(btnidccar), 32'd0);
    chk("trip_dc0",       32'(doorcnt),   32'd0);
    adv(1);                                     // e25
    chk("trip_dest_none", 32'(dest),      32'd0);
    adv(10);                                    // e35
    chk("trip_door_e35",  32'(state),     32'd3);
    chk("trip_dc2",       32'(doorcnt),   32'd2);
    adv(1);                                     // e36
    chk("trip_idle",      32'(state),     32'd0);

    // SCAN ordering from floor 3
    btncar = 5'b10000;
    adv(1);                                     // e37
    btncar = '0;
    adv(1);                                     // e38
    chk("scan_dest5",     32'(dest),      32'd5);
    adv(1);                                     // e39
    chk("scan_up",        32'(state),     32'd1);
    btnout = 5'b00010;
    btncar = 5'b01000;
    adv(1);                                     // e40
    btnout = '0;
    btncar = '0;
    chk("scan_car",       32'(btnidccar), 32'b11000);
    chk("scan_out",       32'(btnidcout), 32'b00010);
    adv(1);                                     // e41
    chk("scan_dest4",     32'(dest),      32'd4);
    adv(6);                                     // e47
    chk("scan_loc_e47",   32'(location),  32'd3);
    chk("scan_st_e47",    32'(state),     32'd1);
    adv(1);                                     // e48
    chk("scan_loc4",      32'(location),  32'd4);
    chk("scan_door4",     32'(state),     32'd3);
    chk("scan_car_e48",   32'(btnidccar), 32'b10000);
    chk("scan_out_e48",   32'(btnidcout), 32'b00010);
    adv(1);                                     // e49
    chk("scan_dest5b",    32'(dest),      32'd5);
    adv(11);                                    // e60
    chk("scan_idle_e60",  32'(state),     32'd0);
    adv(1);                                     // e61
    chk("scan_up2",       32'(state),     32'd1);
    chk("scan_dir_up",    32'(dir),       32'd1);
    adv(11);                                    // e72
    chk("scan_loc5",      32'(location),  32'd5);
    chk("scan_door5",     32'(state),     32'd3);
    chk("scan_car_e72",   32'(btnidccar), 32'd0);
    adv(1);                                     // e73
    chk("scan_dest2",     32'(dest),      32'd2);
    adv(12);                                    // e85
    chk("scan_dn",        32'(state),     32'd2);
    chk("scan_dir_dn",    32'(dir),       32'd0);
    adv(35);                                    // e120
    chk("scan_loc2",      32'(location),  32'd2);
    chk("scan_door2",     32'(state),     32'd3);
    chk("scan_out_clr",   32'(btnidcout), 32'd0);
    adv(1);                                     // e121
    chk("scan_dest0",     32'(dest),      32'd0);
    adv(11);                                    // e132
    chk("scan_idle",      32'(state),     32'd0);

    // Door held by open, press at current floor ignored, closed by shut
    open = 1'b1;
    adv(1);                                     // e133
    chk("hold_door",      32'(state),     32'd3);
    chk("hold_dc0",       32'(doorcnt),   32'd0);
    btncar = 5'b00010;
    adv(1);                                     // e134
    btncar = '0;
    chk("hold_btn_mask",  32'(btnidccar), 32'd0);
    adv(18);                                    // e152
    chk("hold_st_e152",   32'(state),     32'd3);
    chk("hold_dc_e152",   32'(doorcnt),   32'd0);
    open = 1'b0;
    shut = 1'b1;
    adv(1);                                     // e153
    shut = 1'b0;
    chk("shut_idle",      32'(state),     32'd0);
    chk("shut_dc0",       32'(doorcnt),   32'd0);

    // Enable freeze mid-move
    btncar = 5'b01000;
    adv(1);                                     // e154
    btncar = '0;
    adv(1);                                     // e155
    chk("frz_dest4",      32'(dest),      32'd4);
    adv(1);                                     // e156
    chk("frz_up",         32'(state),     32'd1);
    chk("frz_dir",        32'(dir),       32'd1);
    chk("frz_mc0",        32'(movecnt),   32'd0);
    adv(4);                                     // e160
    chk("frz_mc1",        32'(movecnt),   32'd1);
    enable = 1'b0;
    adv(10);                                    // e170
    chk("frz_loc_hold",   32'(location),  32'd2);
    chk("frz_mc_hold",    32'(movecnt),   32'd1);
    chk("frz_st_hold",    32'(state),     32'd1);
    enable = 1'b1;
    adv(3);                                     // e173
    chk("frz_mc_e173",    32'(movecnt),   32'd1);
    adv(1);                                     // e174
    chk("frz_mc_e174",    32'(movecnt),   32'd2);
    adv(3);                                     // e177
    chk("frz_loc_e177",   32'(location),  32'd2);
    adv(1);                                     // e178
    chk("frz_loc3",       32'(location),  32'd3);
    chk("frz_mc_wrap",    32'(movecnt),   32'd0);
    chk("frz_st_e178",    32'(state),     32'd1);

    // Reset mid-move with floors 4 and 5 pending, enable low
    btnout = 5'b10000;
    adv(1);                                     // e179
    btnout = '0;
    chk("mrst_out",       32'(btnidcout), 32'b10000);
    chk("mrst_car",       32'(btnidccar), 32'b01000);
    resetn = 1'b1;
    enable = 1'b0;
    adv(1);                                     // e180
    chk_reset("mrst");
    resetn = 1'b0;
    enable = 1'b1;
    btncar = 5'b00010;
    adv(1);
    btncar = '0;
    chk("post_car",       32'(btnidccar), 32'b00010);
    chk("post_out",       32'(btnidcout), 32'd0);
    adv(1);
    chk("post_dest",      32'(dest),      32'd2);
    adv(1);
    chk("post_up",        32'(state),     32'd1);
    chk("post_mc0",       32'(movecnt),   32'd0);
    adv(1);
    chk("post_presc",     32'(movecnt),   32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
